// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes at accept time into a two-entry skid buffer.
// Define IMM_GEN_ZIMM_EN to report CSR*I forms as Z-format with a zero-extended uimm.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] FmtZ    = 3'd6;
`endif

  logic             out_valid_q, skid_valid_q;
  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [2:0]       out_fmt_q, skid_fmt_q;
  logic             out_illegal_q, skid_illegal_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;
  logic             accept, deliver;

  assign in_ready    = !skid_valid_q;
  assign accept      = in_valid && in_ready;
  assign deliver     = out_valid_q && out_ready;

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FmtNone;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0000111: begin
        dec_fmt = FmtI;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
        if (in_instr[14]) begin
          dec_fmt = FmtZ;
          dec_imm = XLEN'(in_instr[19:15]);
        end else begin
          dec_fmt = FmtI;
          dec_imm = XLEN'($signed(in_instr[31:20]));
        end
`else
        dec_fmt = FmtI;
        dec_imm = XLEN'($signed(in_instr[31:20]));
`endif
      end
      7'b0100011, 7'b0100111: begin
        dec_fmt = FmtS;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FmtB;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FmtU;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FmtJ;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      skid_valid_q   <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FmtNone;
      out_illegal_q  <= 1'b0;
      out_tag_q      <= '0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FmtNone;
      skid_illegal_q <= 1'b0;
      skid_tag_q     <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; only occupancy is cleared.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (deliver) begin
        out_imm_q     <= skid_imm_q;
        out_fmt_q     <= skid_fmt_q;
        out_illegal_q <= skid_illegal_q;
        out_tag_q     <= skid_tag_q;
        skid_valid_q  <= 1'b0;
      end
    end else if (accept && (!out_valid_q || deliver)) begin
      out_valid_q   <= 1'b1;
      out_imm_q     <= dec_imm;
      out_fmt_q     <= dec_fmt;
      out_illegal_q <= dec_illegal;
      out_tag_q     <= in_tag;
    end else if (accept) begin
      skid_valid_q   <= 1'b1;
      skid_imm_q     <= dec_imm;
      skid_fmt_q     <= dec_fmt;
      skid_illegal_q <= dec_illegal;
      skid_tag_q     <= in_tag;
    end else if (deliver) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are scored
// against an independent decode model through an in-order expectation queue.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        ir32, ov32, ill32, ir64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] t);
    exp_t e;
    e.tag = t;
    e.ill = 1'b0;
    e.imm = 64'd0;
    e.fmt = 3'd0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h07: begin
        e.fmt = 3'd1; e.imm = {{52{i[31]}}, i[31:20]};
      end
      7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
        if (i[14]) begin
          e.fmt = 3'd6; e.imm = {59'd0, i[19:15]};
        end else begin
          e.fmt = 3'd1; e.imm = {{52{i[31]}}, i[31:20]};
        end
`else
        e.fmt = 3'd1; e.imm = {{52{i[31]}}, i[31:20]};
`endif
      end
      7'h23, 7'h27: begin
        e.fmt = 3'd2; e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        e.fmt = 3'd3; e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4; e.imm = {{32{i[31]}}, i[31:12], 12'h000};
      end
      7'h6F: begin
        e.fmt = 3'd5; e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against the queue at the negedge, update the queue with the
  // handshakes the model predicts, then move #1 past the next rising edge.
  task automatic step();
    int   n;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      n = q.size();
      chk("out_valid32", {63'd0, ov32}, {63'd0, n > 0});
      chk("out_valid64", {63'd0, ov64}, {63'd0, n > 0});
      chk("in_ready32", {63'd0, ir32}, {63'd0, n < 2});
      chk("in_ready64", {63'd0, ir64}, {63'd0, n < 2});
      if (n > 0) begin
        e = q[0];
        chk("imm32", {32'd0, imm32}, {32'd0, e.imm[31:0]});
        chk("imm64", imm64, e.imm);
        chk("fmt32", {61'd0, fmt32}, {61'd0, e.fmt});
        chk("fmt64", {61'd0, fmt64}, {61'd0, e.fmt});
        chk("illegal", {62'd0, ill32, ill64}, {62'd0, e.ill, e.ill});
        chk("tag", {tag32, tag64}, {e.tag, e.tag});
      end
      if (flush) begin
        q.delete();
      end else begin
        if (n > 0 && out_ready) void'(q.pop_front());
        if (in_valid && n < 2) q.push_back(model(in_instr, in_tag));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] tag);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    step();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    for (int k = 0; k < cycles; k++) step();
  endtask

  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h07, 7'h73, 7'h23, 7'h27,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33, 7'h00};

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h0000_0013; in_tag = 32'hDEAD;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;

    // Reset values, including the data registers.
    @(negedge clk);
    chk("rst_imm32", {32'd0, imm32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fmt", {58'd0, fmt32, fmt64}, 64'd0);
    chk("rst_illegal", {62'd0, ill32, ill64}, 64'd0);
    chk("rst_tag", {tag32, tag64}, 64'd0);
    @(posedge clk); #1;
    idle(1);

    send(32'hFFF0_0093, 32'h100);                  // addi x1,x0,-1
    idle(2);
    send(32'hFE11_2E23, 32'h104);                  // sw x1,-4(x2)
    send(32'h0080_006F, 32'h108);                  // jal x0,8
    idle(2);

    // Backpressure: third beq is refused while the skid entry is occupied.
    out_ready = 1'b0;
    send(32'h0000_0463, 32'd1);
    send(32'hFE00_0EE3, 32'd2);
    send(32'h0020_8663, 32'd3);
    send(32'h0020_8663, 32'd3);
    out_ready = 1'b1;
    send(32'h0020_8663, 32'd3);
    send(32'h0020_8663, 32'd3);
    idle(2);

    send(32'h8000_00B7, 32'h200);                  // lui x1,0x80000
    send(32'h0000_1117, 32'h204);                  // auipc x2,1
    idle(2);

    // Illegal opcode, fill to TWO, then flush with a live input in the same cycle.
    out_ready = 1'b0;
    send(32'h0000_007F, 32'h300);
    send(32'hFFC1_2083, 32'h304);
    send(32'hFFC1_2083, 32'h304);
    flush = 1'b1;
    send(32'h0000_0013, 32'h308);
    flush = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(1);

    send(32'h3002_D073, 32'h400);                  // csrrwi x0,mstatus,5
    send(32'h3002_9073, 32'h404);                  // csrrw x0,mstatus,x5
    idle(2);

    // Reset while in TWO discards both entries.
    out_ready = 1'b0;
    send(32'h0000_0463, 32'h500);
    send(32'h0000_0463, 32'h504);
    rst = 1'b1;
    send(32'h0000_0463, 32'h508);
    rst = 1'b0;
    idle(2);
    out_ready = 1'b1;

    // Random traffic with random backpressure and occasional flushes.
    for (int k = 0; k < 300; k++) begin
      r         = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = {r[31:7], ops[$urandom_range(0, 13)]};
      in_tag    = k;
      step();
    end
    flush = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
